// File: rtl/decoder_pkg.sv
// Shared encodings and width helper for the one-hot decoder family.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SWEEP
  } state_e;

  function automatic int unsigned onehot_width(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

endpackage

// File: rtl/onehot_enc_dec.sv
// Combinational index-to-one-hot decoder with enable; all-zero when disabled.
module onehot_enc_dec
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 2,
  localparam int unsigned OUT_W = onehot_width(SEL_W)
) (
  input  logic             en_i,
  input  logic [SEL_W-1:0] idx_i,
  output logic [OUT_W-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_sweep_decoder.sv
// Registered binary-to-one-hot decoder with single-shot DIRECT mode and an
// auto-stepping SWEEP mode holding each line for dwell+1 enabled cycles.
module onehot_sweep_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 4,
  localparam int unsigned OUT_W  = onehot_width(SEL_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  state_e               state_q, state_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0]   dwell_lat_q, dwell_lat_d;
  logic [SEL_W-1:0]     lines_left_q, lines_left_d;
  logic                 out_valid_q, out_valid_d;

  logic [SEL_W-1:0]     dec_idx;
  logic [OUT_W-1:0]     dec_onehot;

  // In IDLE the decoder sees the requested index; in SWEEP it sees the next line.
  assign dec_idx = (state_q == ST_IDLE) ? sel : idx_q + 1'b1;

  onehot_enc_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .en_i     (1'b1),
    .idx_i    (dec_idx),
    .onehot_o (dec_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_q        <= '0;
      idx_q        <= '0;
      dwell_cnt_q  <= '0;
      dwell_lat_q  <= '0;
      lines_left_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      idx_q        <= idx_d;
      dwell_cnt_q  <= dwell_cnt_d;
      dwell_lat_q  <= dwell_lat_d;
      lines_left_q <= lines_left_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    idx_d        = idx_q;
    dwell_cnt_d  = dwell_cnt_q;
    dwell_lat_d  = dwell_lat_q;
    lines_left_d = lines_left_q;
    out_valid_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          out_d       = dec_onehot;
          out_valid_d = 1'b1;
          if (mode == MODE_SWEEP) begin
            state_d      = ST_SWEEP;
            idx_d        = sel;
            dwell_cnt_d  = dwell;
            dwell_lat_d  = dwell;
            lines_left_d = SEL_W'(OUT_W - 1);
          end
        end
      end
      ST_SWEEP: begin
        // en low freezes the sweep in place.
        if (en) begin
          if (dwell_cnt_q != '0) begin
            dwell_cnt_d = dwell_cnt_q - 1'b1;
          end else if (lines_left_q != '0) begin
            idx_d        = idx_q + 1'b1;
            out_d        = dec_onehot;
            dwell_cnt_d  = dwell_lat_q;
            lines_left_d = lines_left_q - 1'b1;
            out_valid_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q == ST_SWEEP);
    done      = (state_q == ST_SWEEP) && en && (dwell_cnt_q == '0) && (lines_left_q == '0);
    out       = en ? out_q : '0;
    out_valid = out_valid_q;
  end

endmodule

// File: tb/tb_onehot_sweep_decoder.sv
// Directed bench: SEL_W=2 and SEL_W=3 decoders plus the bare one-hot decoder.
module tb_onehot_sweep_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en, mode, in_valid;
  logic [1:0] sel;
  logic [3:0] dwell;
  logic       in_ready, out_valid, busy, done;
  logic [3:0] out;

  logic       en3, mode3, in_valid3;
  logic [2:0] sel3;
  logic [3:0] dwell3;
  logic       in_ready3, out_valid3, busy3, done3;
  logic [7:0] out3;

  logic       enc_en;
  logic [1:0] enc_idx;
  logic [3:0] enc_out;

  int checks = 0;
  int errors = 0;

  logic [3:0] legacy   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] wrap_seq [8] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000,
                               4'b0001, 4'b0001, 4'b0010, 4'b0010};
  logic [7:0] w3_seq   [8] = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  onehot_sweep_decoder #(.SEL_W(2), .DWELL_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .dwell(dwell), .out(out),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  onehot_sweep_decoder #(.SEL_W(3), .DWELL_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .dwell(dwell3), .out(out3),
    .out_valid(out_valid3), .busy(busy3), .done(done3)
  );

  onehot_enc_dec #(.SEL_W(2)) u_enc (
    .en_i(enc_en), .idx_i(enc_idx), .onehot_o(enc_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; in_valid = 1'b0; sel = '0; dwell = '0;
    en3 = 1'b1; mode3 = 1'b0; in_valid3 = 1'b0; sel3 = '0; dwell3 = '0;
    enc_en = 1'b0; enc_idx = '0;
    #3;
    checks++;
    if (out !== 4'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs out=%b ov=%b busy=%b done=%b required 0000 0 0 0",
               out, out_valid, busy, done);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready in_ready=%b required 1", in_ready);
    end
    checks++;
    if (out3 !== 8'h00 || busy3 !== 1'b0 || in_ready3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_w3 out=%h busy=%b rdy=%b required 00 0 1", out3, busy3, in_ready3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_enc_truth();
    logic [3:0] exp;
    for (int e = 0; e < 2; e++) begin
      for (int i = 0; i < 4; i++) begin
        enc_en  = e[0];
        enc_idx = i[1:0];
        #1;
        exp = e[0] ? legacy[i] : 4'b0000;
        checks++;
        if (enc_out !== exp) begin
          errors++;
          $display("FAIL enc_truth en=%0d idx=%0d got %b required %b", e, i, enc_out, exp);
        end
      end
    end
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = i[1:0];
      tick();
      checks++;
      if (out !== legacy[i] || out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL direct_%0d out=%b ov=%b rdy=%b required %b 1 1",
                 i, out, out_valid, in_ready, legacy[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out !== 4'b1000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL direct_hold out=%b ov=%b required 1000 0", out, out_valid);
    end
  endtask

  task automatic test_enable_gating();
    sel = 2'd2; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    en = 1'b0;
    #1;
    checks++;
    if (out !== 4'b0000 || u_dut2.out_q !== 4'b0100) begin
      errors++;
      $display("FAIL gate_off out=%b out_q=%b required 0000 0100", out, u_dut2.out_q);
    end
    en = 1'b1;
    #1;
    checks++;
    if (out !== 4'b0100 || out_valid !== 1'b0) begin
      errors++; $display("FAIL gate_on out=%b ov=%b required 0100 0", out, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL gate_no_pulse ov=%b required 0", out_valid);
    end
  endtask

  task automatic test_sweep_wrap();
    mode = 1'b1; sel = 2'd2; dwell = 4'd1; in_valid = 1'b1;
    tick();
    // A DIRECT request held during the sweep must wait until IDLE.
    mode = 1'b0; sel = 2'd0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (out !== wrap_seq[c]) begin
        errors++; $display("FAIL wrap_out_%0d got %b required %b", c, out, wrap_seq[c]);
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL wrap_busy_%0d busy=%b rdy=%b required 1 0", c, busy, in_ready);
      end
      checks++;
      if (done !== (c == 7)) begin
        errors++; $display("FAIL wrap_done_%0d got %b required %b", c, done, (c == 7));
      end
      checks++;
      if (out_valid !== ((c % 2) == 0)) begin
        errors++;
        $display("FAIL wrap_ov_%0d got %b required %b", c, out_valid, ((c % 2) == 0));
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || out !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_end busy=%b rdy=%b done=%b out=%b required 0 1 0 0010",
               busy, in_ready, done, out);
    end
    tick();
    checks++;
    if (out !== 4'b0001 || out_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_held_req out=%b ov=%b required 0001 1", out, out_valid);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_pause();
    mode = 1'b1; sel = 2'd0; dwell = 4'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out !== 4'b0001) begin
      errors++; $display("FAIL pause_l0 got %b required 0001", out);
    end
    tick();
    checks++;
    if (out !== 4'b0010) begin
      errors++; $display("FAIL pause_l1 got %b required 0010", out);
    end
    tick();
    en = 1'b0;
    #1;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (out !== 4'b0000 || busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL pause_frozen_%0d out=%b busy=%b done=%b rdy=%b required 0000 1 0 0",
                 p, out, busy, done, in_ready);
      end
      tick();
    end
    en = 1'b1;
    #1;
    checks++;
    if (out !== 4'b0100 || done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume out=%b done=%b ov=%b required 0100 0 0", out, done, out_valid);
    end
    tick();
    checks++;
    if (out !== 4'b1000 || done !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pause_last out=%b done=%b ov=%b required 1000 1 1", out, done, out_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || out !== 4'b1000) begin
      errors++;
      $display("FAIL pause_end busy=%b rdy=%b done=%b out=%b required 0 1 0 1000",
               busy, in_ready, done, out);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic saw_bad;
    mode = 1'b1; sel = 2'd0; dwell = 4'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid out=%b busy=%b done=%b ov=%b required 0000 0 0 0",
               out, busy, done, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) saw_bad = 1'b1;
    end
    checks++;
    if (saw_bad !== 1'b0) begin
      errors++; $display("FAIL rst_abandon saw done/busy after reset got 1 required 0");
    end
    mode = 1'b0; sel = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out !== 4'b0010 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_direct out=%b ov=%b required 0010 1", out, out_valid);
    end
    tick();
  endtask

  task automatic test_width3();
    mode3 = 1'b1; sel3 = 3'd7; dwell3 = 4'd0; in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (out3 !== w3_seq[c] || done3 !== (c == 7) || busy3 !== 1'b1) begin
        errors++;
        $display("FAIL w3_%0d out=%h done=%b busy=%b required %h %b 1",
                 c, out3, done3, busy3, w3_seq[c], (c == 7));
      end
      tick();
    end
    checks++;
    if (busy3 !== 1'b0 || in_ready3 !== 1'b1 || out3 !== 8'h40) begin
      errors++;
      $display("FAIL w3_end busy=%b rdy=%b out=%h required 0 1 40", busy3, in_ready3, out3);
    end
  endtask

  initial begin
    test_reset();
    test_enc_truth();
    test_direct();
    test_enable_gating();
    test_sweep_wrap();
    test_pause();
    test_reset_mid_sweep();
    test_width3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/onehot_sweep_decoder.md
Name: onehot_sweep_decoder

Overview:
- Parametrised, registered binary-to-one-hot decoder. Generalises the fixed 2x4 enable decoder to SEL_W select bits.
- Two modes:
  - DIRECT: decode one select value per handshake.
  - SWEEP: auto-step the one-hot output through every line, starting at a given index, with a programmable dwell per line.
- Drives chip-select / row-select / mux-enable fans in the combinational-circuits lab designs; replaces hand-instantiated 2x4 and 3x8 decoders.

Parameters:
- SEL_W, 2, select width in bits (1..6).
- OUT_W, 1<<SEL_W, number of one-hot lines. Localparam; derived and not overridable.
- DWELL_W, 4, width of the dwell count. Each line is held dwell+1 cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  output enable / run enable.
- mode  input  1  0 = DIRECT, 1 = SWEEP. Sampled only at handshake.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- sel  input  SEL_W  decode index (DIRECT) or start index (SWEEP).
- dwell  input  DWELL_W  cycles-minus-one per line (SWEEP). Sampled at handshake.
- out  output  OUT_W  one-hot output, or all-zero.
- out_valid  output  1  one-cycle pulse when a new out value is first presented.
- busy  output  1  high while in SWEEP state.
- done  output  1  one-cycle pulse on the final cycle of a sweep.

Behaviour:
- Reset (async, rst_n low), effective immediately and mid-operation: state=IDLE, out_q=0, idx=0, dwell_cnt=0, lines_left=0, out_valid=0, done=0, busy=0, in_ready=1 after release. An in-progress sweep is abandoned with no done pulse.
- out = out_q when en=1; out = 0 when en=0 (combinational gate). out_q is never multi-hot.
- in_ready = (state==IDLE), registered-state-derived, independent of en.
- Handshake: accept on the rising edge where in_valid && in_ready. Inputs are sampled only at that edge.
- State IDLE:
  - Accept with mode=0 (DIRECT): next cycle out_q = 1<<sel and out_valid=1 for one cycle. Stay IDLE, so back-to-back requests are accepted every cycle. out_q holds the last decode until the next accept or reset.
  - Accept with mode=1 (SWEEP): next cycle out_q = 1<<sel, idx=sel, dwell_cnt=dwell, lines_left=OUT_W-1, out_valid=1, then go to SWEEP.
  - No accept: all registers hold.
- State SWEEP (busy=1, in_ready=0):
  - If en=0: dwell_cnt, idx and lines_left freeze. out reads 0. Resumes exactly where it paused when en=1.
  - If en=1 and dwell_cnt>0: dwell_cnt decrements.
  - If en=1, dwell_cnt==0 and lines_left>0: idx = idx+1 mod OUT_W (wraps OUT_W-1 -> 0), out_q=1<<idx_next, dwell_cnt=dwell_latched, lines_left decrements, out_valid=1.
  - If en=1, dwell_cnt==0 and lines_left==0: done=1 in that cycle (combinational from state), then go to IDLE. out_q keeps the last line.
- Total sweep length with en held high: OUT_W*(dwell+1) cycles in SWEEP. done is asserted in the last of them.
- Requests presented during SWEEP are not accepted (in_ready=0). Requester holds in_valid.
- dwell=0 gives one line per cycle.
- Latency: DIRECT is 1 cycle from accept edge to out update.

Decomposition:
- Shared package/header `decoder_pkg`: mode encodings MODE_DIRECT=0 / MODE_SWEEP=1, state encodings ST_IDLE / ST_SWEEP, and a constant function for the one-hot width.
- One natural sub-module: `onehot_enc_dec`, the pure combinational parametrised index-to-one-hot decoder with enable. It is reused in the registered path and is directly testable against the legacy 2x4 truth table.

Test Plan (SEL_W=2, DWELL_W=4 unless noted):
- DIRECT sweep of all selects: en=1, mode=0, sel=0..3 on consecutive cycles with in_valid=1 -> out = 0001, 0010, 0100, 1000 one cycle after each accept; out_valid high 4 consecutive cycles; in_ready stays 1.
- Enable gating: decode sel=2, then drop en -> out=0000 while out_q keeps 0100; raise en -> out=0100 with no new out_valid.
- SWEEP with wrap: mode=1, sel=2, dwell=1 -> out sequence 0100,0100,1000,1000,0001,0001,0010,0010 (8 cycles); done pulses on the 8th; busy high for those 8 cycles; in_ready=0 throughout.
- Pause: sweep sel=0, dwell=0; drop en for 3 cycles after the second line -> out=0000 during the pause; sequence resumes at 0100; done arrives 3 cycles later than unpaused.
- Reset mid-sweep: assert rst_n=0 asynchronously between clock edges during a sweep -> out=0, busy=0, done never pulses; after release in_ready=1 and a DIRECT sel=1 yields 0010.
- Width generalisation with SEL_W=3: SWEEP sel=7, dwell=0 -> outputs 0x80, 0x01, 0x02, … 0x40 over 8 cycles; done on the 0x40 cycle.
